// File: rtl/cache_miss_ctrl_if.sv
// Cache <-> miss controller <-> dmem signal bundle.
// Latency: none, wires only.
// Backpressure: none; the controller holds the pipeline through stall.
//
// master: cache/dmem side (drives the miss request and the dmem read data)
// slave : cache_miss_ctrl (drives the dmem request, refill line, update, stall)
interface cache_miss_ctrl_if;
  // cache -> controller
  logic              miss;          // miss, already qualified with MEM_RDEN
  logic              victim_dirty;  // LRU victim is valid and dirty
  logic [31:0]       miss_addr;     // CPU address that missed
  logic [31:0]       wb_addr;       // line-aligned victim address
  logic [3:0][31:0]  wb_words;      // victim line data
  // dmem -> controller
  logic [3:0][31:0]  mem_rd_words;  // line read from dmem
  // controller -> dmem
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [3:0][31:0]  mem_wdata;
  // controller -> cache / pipeline
  logic              update;        // one-cycle install pulse
  logic [3:0][31:0]  fill_words;    // registered refill line
  logic              stall;

  modport master (
    output miss, victim_dirty, miss_addr, wb_addr, wb_words, mem_rd_words,
    input  mem_addr, mem_we, mem_wdata, update, fill_words, stall
  );

  modport slave (
    input  miss, victim_dirty, miss_addr, wb_addr, wb_words, mem_rd_words,
    output mem_addr, mem_we, mem_wdata, update, fill_words, stall
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Data-cache miss controller: optional victim writeback, line refill, install pulse.
// Latency: clean miss L+1 cycles to update, dirty miss 2L+1 (L = MEM_LATENCY).
// Backpressure: stall held from the miss cycle through the update cycle.
//
// Ports:
//   CLK, RST_N   clock and synchronous active-low reset
//   bus          cache_miss_ctrl_if.slave (miss request in, dmem request out,
//                refill line / update / stall back to the cache)
//   perf_miss_cnt, perf_wb_cnt  (only when CACHE_MISS_PERF_EN is defined)
//                accepted transactions / victim writebacks, wrapping counters
// Build option: define CACHE_MISS_PERF_EN to add the performance counters.
module cache_miss_ctrl #(
  parameter int MEM_LATENCY = 2,  // cycles per dmem access, 1..15
  parameter int BLOCK_WORDS = 4   // words per line, fixed at 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  cache_miss_ctrl_if.slave        bus
`ifdef CACHE_MISS_PERF_EN
  ,
  output logic [31:0]             perf_miss_cnt,
  output logic [31:0]             perf_wb_cnt
`endif
);

  // Counter runs 0..L-1 inside WB and FILL; L-1 marks the last access cycle.
  localparam logic [3:0]  LAST_CNT  = 4'(MEM_LATENCY - 1);
  // Clears the byte-within-line bits of the miss address.
  localparam logic [31:0] LINE_MASK = ~(32'(BLOCK_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic             w_cnt_last;
  logic             w_accept;
  logic             w_stall;
  logic             w_mem_we;
  logic             w_update;

  logic [31:0]      r_miss_addr;
  logic [31:0]      r_wb_addr;
  logic [3:0][31:0] r_wb_words;
  logic [3:0][31:0] r_fill_words;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_last  = (r_cnt == LAST_CNT);
    w_accept    = 1'b0;
    w_stall     = 1'b1;
    w_mem_we    = 1'b0;
    w_update    = 1'b0;
    case (r_state)
      IDLE: begin
        // Combinational so the pipeline is frozen in the miss cycle itself.
        w_stall = bus.miss;
        if (bus.miss) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        w_mem_we = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_cnt_last) begin
          w_state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        w_update    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access cycle counter: restarts on every state change
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= 4'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 4'd0;
    end else if (r_state == WB || r_state == FILL) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latches: captured only when a transaction is accepted, so input
  // changes mid-transaction have no effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_miss_addr <= 32'd0;
      r_wb_addr   <= 32'd0;
      r_wb_words  <= '0;
    end else if (w_accept) begin
      r_miss_addr <= bus.miss_addr;
      r_wb_addr   <= bus.wb_addr;
      r_wb_words  <= bus.wb_words;
    end
  end

  // Refill line: dmem data is only valid on the final FILL cycle; data seen
  // during WB (zeros while writing) is never captured.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_fill_words <= '0;
    end else if (r_state == FILL && w_cnt_last) begin
      r_fill_words <= bus.mem_rd_words;
    end
  end

`ifdef CACHE_MISS_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_miss_cnt <= 32'd0;
      perf_wb_cnt   <= 32'd0;
    end else begin
      if (w_accept) begin
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
      if (w_accept && w_state_nxt == WB) begin
        perf_wb_cnt <= perf_wb_cnt + 32'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs. mem_addr/mem_wdata come straight from the latches, so they hold
  // their last value in IDLE and read 0 after reset.
  // ---------------------------------------------------------------------------
  assign bus.mem_addr   = (r_state == WB) ? r_wb_addr : (r_miss_addr & LINE_MASK);
  assign bus.mem_wdata  = r_wb_words;
  assign bus.mem_we     = w_mem_we;
  assign bus.update     = w_update;
  assign bus.fill_words = r_fill_words;
  assign bus.stall      = w_stall;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with a behavioural dmem model.
// Latency: checks each cycle of clean, dirty, back-to-back and aborted misses.
// Backpressure: stall is checked cycle by cycle against the expected schedule.
module tb_cache_miss_ctrl;

  localparam int L = 2;

  logic CLK;
  logic RST_N;
  cache_miss_ctrl_if bus ();

`ifdef CACHE_MISS_PERF_EN
  logic [31:0] perf_miss_cnt;
  logic [31:0] perf_wb_cnt;
`endif

  cache_miss_ctrl #(
    .MEM_LATENCY (L),
    .BLOCK_WORDS (4)
  ) u_dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .bus           (bus)
`ifdef CACHE_MISS_PERF_EN
    ,
    .perf_miss_cnt (perf_miss_cnt),
    .perf_wb_cnt   (perf_wb_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // dmem model: 256 words, initial word at byte address a is D000_0000 | a.
  // Reads return zeros while writing.
  // ---------------------------------------------------------------------------
  logic [31:0] dmem [0:255];

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'hD000_0000 | (32'(i) << 2);
    end else if (bus.mem_we) begin
      for (int k = 0; k < 4; k++) dmem[8'(bus.mem_addr[9:2] + 8'(k))] <= bus.mem_wdata[k];
    end
  end

  always_comb begin
    bus.mem_rd_words = '0;
    if (!bus.mem_we) begin
      for (int k = 0; k < 4; k++) bus.mem_rd_words[k] = dmem[8'(bus.mem_addr[9:2] + 8'(k))];
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter and update-pulse monitor
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int upd_cnt = 0;
  int last_upd_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.update === 1'b1) begin
      upd_cnt      <= upd_cnt + 1;
      last_upd_cyc <= cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hD000_0000 | (base + 32'(4 * k));
    return r;
  endfunction

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after a rising edge in an IDLE cycle. Presents a miss, then
  // scrambles every cache input (the DUT must ignore them), checks every cycle
  // through UPDATE, and returns 1ns into the following IDLE cycle with miss=0.
  task automatic do_miss(input logic [31:0] a, input logic d,
                         input logic [31:0] wa, input logic [3:0][31:0] ww);
    logic [31:0] fill_base;
    fill_base        = {a[31:4], 4'b0000};
    bus.miss         = 1'b1;
    bus.miss_addr    = a;
    bus.victim_dirty = d;
    bus.wb_addr      = wa;
    bus.wb_words     = ww;
    @(negedge CLK);
    chk("c0_stall", 128'(bus.stall), 128'(1'b1));
    chk("c0_we", 128'(bus.mem_we), 128'(1'b0));
    next_cyc();
    bus.miss         = 1'b0;
    bus.miss_addr    = 32'h0000_FFF0;
    bus.victim_dirty = ~d;
    bus.wb_addr      = 32'hDEAD_0000;
    bus.wb_words     = '1;
    if (d) begin
      for (int i = 0; i < L; i++) begin
        @(negedge CLK);
        chk("wb_we", 128'(bus.mem_we), 128'(1'b1));
        chk("wb_addr", 128'(bus.mem_addr), 128'(wa));
        chk("wb_wdata", 128'(bus.mem_wdata), 128'(ww));
        chk("wb_stall", 128'(bus.stall), 128'(1'b1));
        chk("wb_upd", 128'(bus.update), 128'(1'b0));
        next_cyc();
      end
    end
    for (int i = 0; i < L; i++) begin
      @(negedge CLK);
      chk("fill_we", 128'(bus.mem_we), 128'(1'b0));
      chk("fill_addr", 128'(bus.mem_addr), 128'(fill_base));
      chk("fill_stall", 128'(bus.stall), 128'(1'b1));
      chk("fill_upd", 128'(bus.update), 128'(1'b0));
      next_cyc();
    end
    @(negedge CLK);
    chk("upd_pulse", 128'(bus.update), 128'(1'b1));
    chk("upd_fill", 128'(bus.fill_words), exp_line(fill_base));
    chk("upd_stall", 128'(bus.stall), 128'(1'b1));
    chk("upd_we", 128'(bus.mem_we), 128'(1'b0));
    next_cyc();
  endtask

  task automatic chk_idle(input string tag);
    @(negedge CLK);
    chk({tag, "_stall"}, 128'(bus.stall), 128'(1'b0));
    chk({tag, "_upd"}, 128'(bus.update), 128'(1'b0));
    chk({tag, "_we"}, 128'(bus.mem_we), 128'(1'b0));
    next_cyc();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    next_cyc();
    next_cyc();
    RST_N = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0][31:0] ww;
    int u0;
    int t1;
    int t2;

    RST_N            = 1'b0;
    bus.miss         = 1'b0;
    bus.victim_dirty = 1'b0;
    bus.miss_addr    = 32'd0;
    bus.wb_addr      = 32'd0;
    bus.wb_words     = '0;
    next_cyc();
    next_cyc();
    RST_N = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_stall", 128'(bus.stall), 128'(1'b0));
    chk("rst_we", 128'(bus.mem_we), 128'(1'b0));
    chk("rst_upd", 128'(bus.update), 128'(1'b0));
    chk("rst_addr", 128'(bus.mem_addr), 128'(32'd0));
    chk("rst_wdata", 128'(bus.mem_wdata), 128'd0);
    chk("rst_fill", 128'(bus.fill_words), 128'd0);
    next_cyc();

    // Clean miss at 0x124, with inputs scrambled mid-transaction
    u0 = upd_cnt;
    do_miss(32'h0000_0124, 1'b0, 32'h0000_03C0, '0);
    chk_idle("clean_done");
    chk("clean_one_upd", 128'(upd_cnt - u0), 128'(1));

    // Dirty miss: victim {A,B,C,D} to 0x240, refill from 0x380
    ww[0] = 32'hAAAA_0001;
    ww[1] = 32'hBBBB_0002;
    ww[2] = 32'hCCCC_0003;
    ww[3] = 32'hDDDD_0004;
    u0 = upd_cnt;
    do_miss(32'h0000_0388, 1'b1, 32'h0000_0240, ww);
    chk_idle("dirty_done");
    chk("dirty_one_upd", 128'(upd_cnt - u0), 128'(1));
    for (int k = 0; k < 4; k++) chk("dmem_wb", 128'(dmem[8'(8'h90 + 8'(k))]), 128'(ww[k]));

    // Back-to-back: second miss presented in the IDLE cycle after UPDATE
    u0 = upd_cnt;
    do_miss(32'h0000_00B4, 1'b0, 32'd0, '0);
    t1 = last_upd_cyc;
    do_miss(32'h0000_01C8, 1'b0, 32'd0, '0);
    t2 = last_upd_cyc;
    chk_idle("b2b_done");
    chk("b2b_two_upd", 128'(upd_cnt - u0), 128'(2));
    chk("b2b_gap", 128'(t2 - t1 - 1), 128'(L + 1));

    // Reset asserted during the second WB cycle
    u0 = upd_cnt;
    bus.miss         = 1'b1;
    bus.miss_addr    = 32'h0000_0064;
    bus.victim_dirty = 1'b1;
    bus.wb_addr      = 32'h0000_02C0;
    bus.wb_words     = ww;
    next_cyc();
    bus.miss = 1'b0;
    @(negedge CLK);
    chk("abort_wb1_we", 128'(bus.mem_we), 128'(1'b1));
    next_cyc();
    RST_N = 1'b0;
    next_cyc();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("abort_we", 128'(bus.mem_we), 128'(1'b0));
    chk("abort_upd", 128'(bus.update), 128'(1'b0));
    chk("abort_stall", 128'(bus.stall), 128'(1'b0));
    chk("abort_addr", 128'(bus.mem_addr), 128'(32'd0));
    chk("abort_fill", 128'(bus.fill_words), 128'd0);
    repeat (6) next_cyc();
    chk("abort_no_upd", 128'(upd_cnt - u0), 128'(0));

`ifdef CACHE_MISS_PERF_EN
    // Performance counters: 3 clean + 2 dirty misses
    do_reset();
    @(negedge CLK);
    chk("perf_rst_miss", 128'(perf_miss_cnt), 128'(32'd0));
    chk("perf_rst_wb", 128'(perf_wb_cnt), 128'(32'd0));
    next_cyc();
    do_miss(32'h0000_0014, 1'b0, 32'd0, '0);
    do_miss(32'h0000_0054, 1'b0, 32'd0, '0);
    do_miss(32'h0000_0094, 1'b0, 32'd0, '0);
    do_miss(32'h0000_03A0, 1'b1, 32'h0000_0300, ww);
    do_miss(32'h0000_03E4, 1'b1, 32'h0000_0340, ww);
    @(negedge CLK);
    chk("perf_miss", 128'(perf_miss_cnt), 128'(32'd5));
    chk("perf_wb", 128'(perf_wb_cnt), 128'(32'd2));
    next_cyc();
    do_reset();
    @(negedge CLK);
    chk("perf_clr_miss", 128'(perf_miss_cnt), 128'(32'd0));
    chk("perf_clr_wb", 128'(perf_wb_cnt), 128'(32'd0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
